// File: rtl/dac_stream_driver.sv
// DAC transmit path: sample FIFO, integer DAC clock divider and power-down/wake sequencing.
// One FIFO sample is presented per DAC_CLK period, changing on the falling DAC_CLK edge.
module dac_stream_driver #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned WAKE_CYCLES = 64
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        enable,
    input  logic [DATA_W-1:0]           s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic                        DAC_CLK,
    output logic                        DAC_PWR,
    output logic [DATA_W-1:0]           DAC_Dout,
    output logic                        underrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        running
);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W  = PTR_W + 1;
    localparam int unsigned DIV_W  = $clog2(CLK_DIV);
    localparam int unsigned WAKE_W = $clog2(WAKE_CYCLES + 1);
    localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_SLEEP,
        S_WAKE,
        S_RUN
    } state_t;

    state_t              r_state;
    logic [DIV_W-1:0]    r_div_cnt;
    logic                r_dac_clk;
    logic                r_pwr;
    logic [DATA_W-1:0]   r_dout;
    logic                r_underrun;
    logic                r_stop;
    logic [WAKE_W-1:0]   r_wake_cnt;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [LVL_W-1:0]    r_level;
    logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];

    logic                w_upd;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic [DIV_W-1:0]    w_div_nxt;

    // Update edge: divider wraps, DAC_CLK falls. r_stop parks the divider at 0 so it never fires.
    assign w_upd     = (r_state != S_SLEEP) && (r_div_cnt == DIV_W'(CLK_DIV - 1));
    assign w_div_nxt = (r_div_cnt == DIV_W'(CLK_DIV - 1)) ? '0 : r_div_cnt + DIV_W'(1);
    assign w_full    = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_push    = s_valid && !w_full;
    assign w_pop     = (r_state == S_RUN) && w_upd && (r_level != '0);

    assign s_ready    = !w_full;
    assign DAC_CLK    = r_dac_clk;
    assign DAC_PWR    = r_pwr;
    assign DAC_Dout   = r_dout;
    assign underrun   = r_underrun;
    assign fifo_level = r_level;
    assign running    = (r_state == S_RUN);

    // Sample storage; contents are don't-care until written, pointers carry the reset.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_SLEEP;
            r_div_cnt  <= '0;
            r_dac_clk  <= 1'b0;
            r_pwr      <= 1'b1;
            r_dout     <= MID;
            r_underrun <= 1'b0;
            r_stop     <= 1'b0;
            r_wake_cnt <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LVL_W'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LVL_W'(1);
            end

            case (r_state)
                S_SLEEP: begin
                    r_div_cnt <= '0;
                    r_dac_clk <= 1'b0;
                    r_pwr     <= 1'b1;
                    r_dout    <= MID;
                    r_stop    <= 1'b0;
                    if (enable) begin
                        r_state    <= S_WAKE;
                        r_pwr      <= 1'b0;
                        r_underrun <= 1'b0;
                        r_wake_cnt <= '0;
                    end
                end
                S_WAKE: begin
                    r_div_cnt <= w_div_nxt;
                    r_dac_clk <= (w_div_nxt >= DIV_W'(CLK_DIV / 2));
                    if (w_upd) begin
                        if (!enable) begin
                            r_state   <= S_SLEEP;
                            r_div_cnt <= '0;
                            r_dac_clk <= 1'b0;
                            r_pwr     <= 1'b1;
                            r_dout    <= MID;
                        end else if (r_wake_cnt == WAKE_W'(WAKE_CYCLES - 1)) begin
                            r_state <= S_RUN;
                        end else begin
                            r_wake_cnt <= r_wake_cnt + WAKE_W'(1);
                        end
                    end
                end
                S_RUN: begin
                    if (r_stop) begin
                        // The last sample had its update edge; power down now.
                        r_state   <= S_SLEEP;
                        r_stop    <= 1'b0;
                        r_div_cnt <= '0;
                        r_dac_clk <= 1'b0;
                        r_pwr     <= 1'b1;
                        r_dout    <= MID;
                    end else begin
                        r_div_cnt <= w_div_nxt;
                        r_dac_clk <= (w_div_nxt >= DIV_W'(CLK_DIV / 2));
                        if (w_upd) begin
                            if (w_pop) begin
                                r_dout <= r_mem[r_rd_ptr];
                            end else begin
                                r_underrun <= 1'b1;
                            end
                            if (!enable) begin
                                r_stop <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= S_SLEEP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_stream_driver.sv
// Bench for dac_stream_driver: reset/pre-fill vector table, directed wake/ramp/drain/stop
// sequences and a randomized run, all checked every cycle against a queue-based reference.
module tb_dac_stream_driver;
    localparam int unsigned DIV   = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned WAKE  = 64;
    localparam logic [7:0]  MID   = 8'h80;

    logic       CLK;
    logic       RST;
    logic       enable;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       DAC_CLK;
    logic       DAC_PWR;
    logic [7:0] DAC_Dout;
    logic       underrun;
    logic [4:0] fifo_level;
    logic       running;

    int n_tests = 0;
    int n_fail  = 0;

    dac_stream_driver #(
        .DATA_W(8), .CLK_DIV(DIV), .FIFO_DEPTH(DEPTH), .WAKE_CYCLES(WAKE)
    ) dut (
        .CLK(CLK), .RST(RST), .enable(enable), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .DAC_CLK(DAC_CLK), .DAC_PWR(DAC_PWR), .DAC_Dout(DAC_Dout),
        .underrun(underrun), .fifo_level(fifo_level), .running(running)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Reference: sample queue plus time since wake-up; mode 0 sleep, 1 wake, 2 run.
    logic [7:0] m_q[$];
    int         m_mode;
    int         m_t;
    bit         m_stop;
    bit         m_pwr;
    bit         m_und;
    logic [7:0] m_dout;

    task automatic m_sleep();
        m_mode = 0;
        m_t    = 0;
        m_stop = 0;
        m_pwr  = 1;
        m_dout = MID;
    endtask

    task automatic model_step();
        bit upd;
        bit push;
        if (RST) begin
            m_q.delete();
            m_und = 0;
            m_sleep();
            return;
        end
        upd  = (m_mode != 0) && !m_stop && ((m_t % DIV) == DIV - 1);
        push = s_valid && (m_q.size() < DEPTH);
        if (m_mode == 2 && upd) begin
            if (m_q.size() > 0) m_dout = m_q.pop_front();
            else                m_und  = 1;
        end
        if (push) m_q.push_back(s_data);
        case (m_mode)
            0: if (enable) begin
                m_mode = 1;
                m_t    = 0;
                m_pwr  = 0;
                m_und  = 0;
            end
            1: begin
                if (upd && !enable) m_sleep();
                else begin
                    if (upd && (m_t + 1) == int'(WAKE * DIV)) m_mode = 2;
                    m_t++;
                end
            end
            default: begin
                if (m_stop) m_sleep();
                else begin
                    if (upd && !enable) m_stop = 1;
                    m_t++;
                end
            end
        endcase
    endtask

    task automatic finish_tb();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
            if (n_fail >= 40) finish_tb();
        end
    endtask

    // Packed as {s_ready, DAC_CLK, DAC_PWR, DAC_Dout, underrun, fifo_level, running}.
    task automatic check_model();
        logic [17:0] act;
        logic [17:0] exp;
        act = {s_ready, DAC_CLK, DAC_PWR, DAC_Dout, underrun, fifo_level, running};
        exp = {1'(m_q.size() != DEPTH), 1'(m_mode != 0 && (m_t % DIV) >= DIV / 2), m_pwr,
               m_dout, m_und, 5'(m_q.size()), 1'(m_mode == 2)};
        check("model", 32'(act), 32'(exp));
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
        check_model();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance to the cycle right after DAC_CLK rises (two CLKs before the update edge).
    task automatic wait_rise(input string name);
        int n;
        n = 0;
        while (DAC_CLK !== 1'b0 && n < 2 * DIV) begin tick(); n++; end
        while (DAC_CLK !== 1'b1 && n < 4 * DIV) begin tick(); n++; end
        check(name, 32'(DAC_CLK), 32'd1);
    endtask

    task automatic wait_change(input logic [7:0] from, input int max, output int cnt);
        cnt = 0;
        while (DAC_Dout === from && cnt < max) begin tick(); cnt++; end
    endtask

    typedef struct {
        logic       rst;
        logic       en;
        logic       valid;
        logic [7:0] data;
        logic       rdy;
        logic [4:0] lvl;
    } vec_t;

    function automatic vec_t mk(logic rst, logic en, logic valid, logic [7:0] data,
                                logic rdy, logic [4:0] lvl);
        vec_t r;
        r.rst = rst; r.en = en; r.valid = valid; r.data = data; r.rdy = rdy; r.lvl = lvl;
        return r;
    endfunction

    initial begin
        vec_t tbl[$];
        int   cnt;
        int   dens;

        // Reset held with enable high, then pre-fill 0x01..0x10 while asleep.
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 5'd0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 5'd0));
        for (int k = 1; k <= 16; k++) tbl.push_back(mk(1'b0, 1'b0, 1'b1, 8'(k), 1'(k != 16), 5'(k)));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 8'hAA, 1'b0, 5'd16));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd16));

        RST = 1'b1; enable = 1'b1; s_valid = 1'b0; s_data = 8'h00;
        foreach (tbl[i]) begin
            RST = tbl[i].rst; enable = tbl[i].en; s_valid = tbl[i].valid; s_data = tbl[i].data;
            tick();
            check($sformatf("vec%0d", i), 32'({s_ready, DAC_CLK, DAC_PWR, DAC_Dout, fifo_level}),
                  32'({tbl[i].rdy, 1'b0, 1'b1, MID, tbl[i].lvl}));
        end

        // Wake: MID for 64 DAC periods, first sample on a falling DAC_CLK.
        s_valid = 1'b0; enable = 1'b1;
        wait_change(MID, 400, cnt);
        check("wake_len", 32'(cnt), 32'd261);
        check("first_sample", 32'(DAC_Dout), 32'h01);
        check("first_fall", 32'(DAC_CLK), 32'd0);

        // Ramp fed at one sample per DAC period behind the pre-filled block.
        for (int k = 2; k <= 40; k++) begin
            s_valid = 1'b1; s_data = 8'(16 + k - 1);
            tick();
            s_valid = 1'b0;
            ticks(3);
            check($sformatf("ramp%0d", k), 32'(DAC_Dout), 32'(k));
            check($sformatf("ramp_lvl%0d", k), 32'(fifo_level), 32'd15);
        end
        check("ramp_und", 32'(underrun), 32'd0);

        // Disable mid-run: one more sample, then power down with FIFO kept.
        enable = 1'b0;
        ticks(4);
        check("stop_last", 32'(DAC_Dout), 32'd41);
        check("stop_pwr_on", 32'(DAC_PWR), 32'd0);
        tick();
        check("stop_state", 32'({DAC_PWR, DAC_CLK, DAC_Dout, running}), 32'({1'b1, 1'b0, MID, 1'b0}));
        check("stop_lvl", 32'(fifo_level), 32'd14);
        ticks(8);
        check("stop_lvl_held", 32'(fifo_level), 32'd14);

        // Re-wake, drain the remaining 14 samples, then underrun.
        enable = 1'b1;
        wait_change(MID, 400, cnt);
        check("rewake_len", 32'(cnt), 32'd261);
        check("rewake_first", 32'(DAC_Dout), 32'd42);
        ticks(52);
        check("drain_last", 32'(DAC_Dout), 32'd55);
        check("drain_no_und", 32'(underrun), 32'd0);
        ticks(4);
        check("und_set", 32'(underrun), 32'd1);
        check("und_hold", 32'(DAC_Dout), 32'd55);

        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = 8'hC0 + 8'(i);
            tick();
        end
        s_valid = 1'b0;
        ticks(16);
        check("und_sticky", 32'(underrun), 32'd1);
        check("refill_out", 32'(DAC_Dout), 32'hC2);
        check("drained", 32'(fifo_level), 32'd0);

        // Push coinciding with a pop at level 1.
        wait_rise("sync_rise1");
        s_valid = 1'b1; s_data = 8'hD0;
        tick();
        check("lvl_one", 32'(fifo_level), 32'd1);
        s_data = 8'hD1;
        tick();
        s_valid = 1'b0;
        check("lvl_one_pp", 32'(fifo_level), 32'd1);
        check("pp_dout", 32'(DAC_Dout), 32'hD0);

        // Push attempt while full on a pop edge: refused, level drops, next push refills.
        s_valid = 1'b1;
        for (int i = 0; i < 24; i++) begin s_data = 8'($urandom); tick(); end
        wait_rise("sync_rise2");
        check("full_lvl", 32'(fifo_level), 32'd16);
        tick();
        check("full_ready", 32'(s_ready), 32'd0);
        tick();
        check("full_pop_lvl", 32'(fifo_level), 32'd15);
        tick();
        check("refill_lvl", 32'(fifo_level), 32'd16);
        s_valid = 1'b0;

        // Power cycle through SLEEP clears underrun.
        enable = 1'b0;
        ticks(8);
        check("sleep_pwr", 32'({DAC_PWR, running, underrun}), 32'({1'b1, 1'b0, 1'b1}));
        enable = 1'b1;
        tick();
        check("und_clear", 32'({underrun, DAC_PWR}), 32'd0);

        // Reset in the middle of RUN.
        ticks(270);
        check("pre_rst_run", 32'(running), 32'd1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("rst_run", 32'({s_ready, DAC_CLK, DAC_PWR, DAC_Dout, underrun, fifo_level, running}),
              32'({1'b1, 1'b0, 1'b1, MID, 1'b0, 5'd0, 1'b0}));

        // Randomized traffic with varying feed density, enable toggles and rare resets.
        dens = 4;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) dens = int'($urandom_range(0, 8));
            RST     = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 399) == 0) enable = !enable;
            s_valid = (int'($urandom_range(0, 7)) < dens);
            s_data  = 8'($urandom);
            tick();
        end

        finish_tb();
    end

endmodule
